// File: rtl/alight_frame_ctrl_if.sv
// Window bus between the atmospheric-light sequencer and the MIN9 dark-channel unit.
// The sequencer drives window enable and centre coordinates; MIN9 returns the window minimum.
interface alight_frame_ctrl_if #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   logic          win_valid;
   logic [XW-1:0] win_x;
   logic [YW-1:0] win_y;
   logic [7:0]    min_in;

   modport master (output win_valid, win_x, win_y, input  min_in);
   modport slave  (input  win_valid, win_x, win_y, output min_in);
endinterface

// File: rtl/alight_frame_ctrl.sv
// Atmospheric-light sequencer: raster-walks interior 3x3 windows, keeps the max of MIN9 results, publishes A.
// Optional macro ALIGHT_COORD_EN: report the coordinates of the brightest window on max_x/max_y.
module alight_frame_ctrl #(
   parameter  int IMG_W   = 64,
   parameter  int IMG_H   = 64,
   parameter  int MIN_LAT = 2,
   parameter  int A_FLOOR = 180,
   localparam int XW      = $clog2(IMG_W),
   localparam int YW      = $clog2(IMG_H)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                hold,
   alight_frame_ctrl_if.master min9,
   output logic                busy,
   output logic                done,
   output logic [7:0]          A,
   output logic                A_valid,
   output logic [XW-1:0]       max_x,
   output logic [YW-1:0]       max_y
);
   localparam int            DW     = (MIN_LAT > 1) ? $clog2(MIN_LAT) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 2);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 2);
   localparam logic [7:0]    FLOOR  = 8'(A_FLOOR);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t             state_q, state_d;
   logic [XW-1:0]      x_q;
   logic [YW-1:0]      y_q;
   logic [DW-1:0]      drain_q;
   logic [MIN_LAT-1:0] vpipe_q;
   logic [7:0]         run_max_q, max_d;
   logic               accept, issue, last_win, drain_last, tail, hit, publish;

   assign accept     = (state_q == IDLE) && start;
   assign issue      = (state_q == ISSUE) && !hold;
   assign last_win   = (x_q == X_LAST) && (y_q == Y_LAST);
   assign drain_last = (drain_q == DW'(MIN_LAT - 1));
   assign tail       = vpipe_q[MIN_LAT-1];
   assign hit        = tail && (min9.min_in > run_max_q);
   assign max_d      = hit ? min9.min_in : run_max_q;
   // The last result lands in the final DRAIN cycle, so A is captured from the merged max on the way into DONE.
   assign publish    = (state_q == DRAIN) && drain_last;

   assign min9.win_valid = issue;
   assign min9.win_x     = x_q;
   assign min9.win_y     = y_q;
   assign busy           = (state_q == ISSUE) || (state_q == DRAIN);
   assign done           = (state_q == DONE);

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ISSUE;
         ISSUE:   if (issue && last_win) state_d = DRAIN;
         DRAIN:   if (drain_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x_q       <= '0;
         y_q       <= '0;
         drain_q   <= '0;
         vpipe_q   <= '0;
         run_max_q <= FLOOR;
         A         <= FLOOR;
         A_valid   <= 1'b0;
      end else begin
         if (accept) begin
            x_q <= XW'(1);
            y_q <= YW'(1);
         end else if (issue && !last_win) begin
            if (x_q == X_LAST) begin
               x_q <= XW'(1);
               y_q <= y_q + YW'(1);
            end else begin
               x_q <= x_q + XW'(1);
            end
         end

         drain_q <= (state_q == DRAIN) ? drain_q + DW'(1) : '0;

         for (int i = MIN_LAT - 1; i > 0; i--) vpipe_q[i] <= vpipe_q[i-1];
         vpipe_q[0] <= issue;

         run_max_q <= accept ? FLOOR : max_d;

         if (publish) begin
            A       <= max_d;
            A_valid <= 1'b1;
         end
      end
   end

`ifdef ALIGHT_COORD_EN
   logic [XW-1:0] xpipe_q [MIN_LAT];
   logic [YW-1:0] ypipe_q [MIN_LAT];
   logic [XW-1:0] best_x_q, best_x_d;
   logic [YW-1:0] best_y_q, best_y_d;

   // NOTE: the coordinate pipe is pure data qualified by vpipe_q, so it carries no reset.
   always_ff @(posedge clock) begin
      for (int i = MIN_LAT - 1; i > 0; i--) begin
         xpipe_q[i] <= xpipe_q[i-1];
         ypipe_q[i] <= ypipe_q[i-1];
      end
      xpipe_q[0] <= x_q;
      ypipe_q[0] <= y_q;
   end

   assign best_x_d = hit ? xpipe_q[MIN_LAT-1] : best_x_q;
   assign best_y_d = hit ? ypipe_q[MIN_LAT-1] : best_y_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         best_x_q <= '0;
         best_y_q <= '0;
         max_x    <= '0;
         max_y    <= '0;
      end else begin
         best_x_q <= accept ? '0 : best_x_d;
         best_y_q <= accept ? '0 : best_y_d;
         if (publish) begin
            max_x <= best_x_d;
            max_y <= best_y_d;
         end
      end
   end
`else
   assign max_x = '0;
   assign max_y = '0;
`endif

endmodule

// File: tb/tb_alight_frame_ctrl.sv
// Randomized scoreboard bench for alight_frame_ctrl on a 5x5 frame with MIN_LAT=2.
// A behavioural MIN9 responder feeds window values; expected windows and frame results are queued and checked by a monitor.
module tb_alight_frame_ctrl;
   localparam int IMG_W   = 5;
   localparam int IMG_H   = 5;
   localparam int MIN_LAT = 2;
   localparam int A_FLOOR = 180;
   localparam int XW      = $clog2(IMG_W);
   localparam int YW      = $clog2(IMG_H);
   localparam int N       = (IMG_W - 2) * (IMG_H - 2);

   typedef struct { int x; int y; } coord_t;
   typedef struct { int a; int mx; int my; int done_cyc; } frame_exp_t;
   typedef struct { int due; logic [7:0] v; } resp_t;

   logic          clock = 1'b0;
   logic          reset, start, hold;
   logic          busy, done, A_valid;
   logic [7:0]    A;
   logic [XW-1:0] max_x;
   logic [YW-1:0] max_y;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] tbl [IMG_W][IMG_H];
   coord_t     cq[$];
   frame_exp_t fq[$];
   resp_t      pend[$];
   int         a_model  = A_FLOOR;
   logic       av_model = 1'b0;
   coord_t     mc;
   frame_exp_t mf;

   alight_frame_ctrl_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) min9();

   alight_frame_ctrl #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .MIN_LAT(MIN_LAT), .A_FLOOR(A_FLOOR)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .hold(hold), .min9(min9),
      .busy(busy), .done(done), .A(A), .A_valid(A_valid), .max_x(max_x), .max_y(max_y)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] win_value(input logic [XW-1:0] x, input logic [YW-1:0] y);
      if (int'(x) < IMG_W && int'(y) < IMG_H) return tbl[int'(x)][int'(y)];
      return 8'h00;
   endfunction

   // Window values per frame: 0 flat 100, 1 single bright window idx 3, 2 tie at idx 2 and 7, else random.
   function automatic void fill_table(input int mode);
      int idx;
      for (int x = 0; x < IMG_W; x++)
         for (int y = 0; y < IMG_H; y++) tbl[x][y] = 8'h00;
      for (int y = 1; y <= IMG_H - 2; y++)
         for (int x = 1; x <= IMG_W - 2; x++) begin
            idx = (y - 1) * (IMG_W - 2) + (x - 1);
            case (mode)
               0: tbl[x][y] = 8'd100;
               1: tbl[x][y] = (idx == 3) ? 8'd200 : 8'd50;
               2: tbl[x][y] = (idx == 2 || idx == 7) ? 8'd220 : 8'd10;
               default:
                  if ($urandom_range(0, 1) == 1) tbl[x][y] = 8'($urandom_range(0, 255));
                  else case ($urandom_range(0, 3))
                     0:       tbl[x][y] = 8'd150;
                     1:       tbl[x][y] = 8'd181;
                     2:       tbl[x][y] = 8'd200;
                     default: tbl[x][y] = 8'd220;
                  endcase
            endcase
         end
   endfunction

   // Monitor and MIN9 responder share one process so their ordering per cycle is fixed.
   always @(negedge clock) begin
      if (reset) begin
         cq.delete();
         pend.delete();
         a_model  = A_FLOOR;
         av_model = 1'b0;
         min9.min_in = 8'($urandom);
      end else begin
         if (min9.win_valid) begin
            if (cq.size() == 0) check("window_expected", 32'(cq.size()), 1);
            else begin
               mc = cq.pop_front();
               check("win_x", 32'(min9.win_x), mc.x);
               check("win_y", 32'(min9.win_y), mc.y);
            end
         end
         if (done) begin
            if (fq.size() == 0) check("done_expected", 32'(fq.size()), 1);
            else begin
               mf = fq.pop_front();
               check("done_cycle", cyc, mf.done_cyc);
               check("A", 32'(A), mf.a);
               check("A_valid", 32'(A_valid), 1);
               check("max_x", 32'(max_x), mf.mx);
               check("max_y", 32'(max_y), mf.my);
               a_model  = mf.a;
               av_model = 1'b1;
            end
         end else begin
            check("A_hold", 32'(A), a_model);
            check("A_valid_hold", 32'(A_valid), 32'(av_model));
         end
         if (pend.size() != 0 && pend[0].due == cyc) begin
            min9.min_in = pend[0].v;
            void'(pend.pop_front());
         end else begin
            min9.min_in = 8'($urandom);
         end
         if (min9.win_valid) pend.push_back('{due: cyc + MIN_LAT, v: win_value(min9.win_x, min9.win_y)});
      end
   end

   // One frame: mask bit k holds cycle k; noisy adds stray starts while busy; start_in_done raises start in DONE.
   task automatic run_frame(input int mode, input logic [31:0] mask, input bit noisy, input bit start_in_done);
      int issued, end_k, total, s0, best, bx, by;
      frame_exp_t f;
      fill_table(mode);
      best = A_FLOOR; bx = 0; by = 0;
      for (int y = 1; y <= IMG_H - 2; y++)
         for (int x = 1; x <= IMG_W - 2; x++) begin
            cq.push_back('{x: x, y: y});
            if (int'(tbl[x][y]) > best) begin
               best = int'(tbl[x][y]); bx = x; by = y;
            end
         end
      issued = 0; end_k = 0;
      while (issued < N) begin
         end_k++;
         if (!(end_k < 32 && mask[end_k])) issued++;
      end
      total = end_k + MIN_LAT + 1;

      @(posedge clock); #1;
      start = 1'b1; hold = 1'b0;
      @(posedge clock); #1;
      s0 = cyc;
      f.a = best;
`ifdef ALIGHT_COORD_EN
      f.mx = bx; f.my = by;
`else
      f.mx = 0; f.my = 0;
`endif
      f.done_cyc = s0 + total - 1;
      fq.push_back(f);
      for (int k = 1; k <= total; k++) begin
         hold = (k < 32 && k < total) ? mask[k] : 1'b0;
         if (k < total) start = noisy && ($urandom_range(0, 2) == 0);
         else           start = start_in_done;
         check("busy", 32'(busy), 32'(k < total));
         if (k < total) begin
            @(posedge clock); #1;
         end
      end
   endtask

   // Start a frame and reset it in cycle 6; no done may follow and A must fall back to the floor.
   task automatic abort_frame();
      fill_table(3);
      for (int y = 1; y <= IMG_H - 2; y++)
         for (int x = 1; x <= IMG_W - 2; x++) cq.push_back('{x: x, y: y});
      @(posedge clock); #1;
      start = 1'b1; hold = 1'b0;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      reset = 1'b1;
      #2;
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      check("abort_A", 32'(A), A_FLOOR);
      check("abort_A_valid", 32'(A_valid), 0);
      check("abort_win_valid", 32'(min9.win_valid), 0);
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; hold = 1'b0;
      #12;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_win_valid", 32'(min9.win_valid), 0);
      check("rst_win_x", 32'(min9.win_x), 0);
      check("rst_win_y", 32'(min9.win_y), 0);
      check("rst_A", 32'(A), A_FLOOR);
      check("rst_A_valid", 32'(A_valid), 0);
      check("rst_max_x", 32'(max_x), 0);
      check("rst_max_y", 32'(max_y), 0);
      @(posedge clock); #1;
      reset = 1'b0;

      run_frame(0, 32'h0, 1'b0, 1'b0);
      run_frame(1, 32'h0, 1'b0, 1'b0);
      run_frame(2, 32'h0, 1'b0, 1'b0);
      run_frame(1, 32'h38, 1'b0, 1'b0);
      abort_frame();
      run_frame(3, 32'h0, 1'b0, 1'b0);
      run_frame(3, 32'h0, 1'b1, 1'b1);
      run_frame(3, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 24; i++)
         run_frame(3, $urandom & $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      @(posedge clock); #1;
      start = 1'b0; hold = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      check("frames_pending", 32'(fq.size()), 0);
      check("windows_pending", 32'(cq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alight_frame_ctrl.md
# alight_frame_ctrl

Frame-level sequencer for atmospheric-light estimation in the dehaze pipeline. Walks every interior 3x3 window of an IMG_W x IMG_H frame in raster order and drives the window coordinates and enable into the MIN9 dark-channel unit. It collects each returned window minimum, tracks the running maximum against a fixed floor, and publishes the frame's atmospheric light A with a one-cycle done pulse.

## Interface
- IMG_W, 64: frame width in pixels (>= 3)
- IMG_H, 64: frame height in pixels (>= 3)
- MIN_LAT, 2: cycles from win_valid to the matching min_in (>= 1)
- A_FLOOR, 180: seed and lower bound of A
- XW/YW (localparam): $clog2(IMG_W) / $clog2(IMG_H)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin a frame; sampled in IDLE only
- hold  in  1  pause window issue (line buffer not ready)
- win_valid  out  1  enable to MIN9 for the current window
- win_x  out  XW  window centre column
- win_y  out  YW  window centre row
- min_in  in  8  MIN9 result, valid MIN_LAT cycles after its win_valid
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse; A is final
- A  out  8  atmospheric light of last completed frame
- A_valid  out  1  high once any frame has completed
- max_x  out  XW  column of brightest window (see Configuration)
- max_y  out  YW  row of brightest window (see Configuration)

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 -> ISSUE; win_x=1, win_y=1, running max = A_FLOOR. start in any other state is ignored.
- ISSUE: win_valid = !hold (combinational). On each cycle with win_valid=1, advance x from 1 to IMG_W-2, then wrap x to 1 and increment y up to IMG_H-2. With hold=1, coordinates freeze and nothing is issued. After window (IMG_W-2, IMG_H-2) is issued -> DRAIN. N = (IMG_W-2)(IMG_H-2) windows.
- A MIN_LAT-deep shift register carries win_valid, plus coordinates when ALIGHT_COORD_EN is defined. When its tail is set, compare min_in against the running max. Strictly greater updates the max, so ties keep the first occurrence. Collection continues through hold, DRAIN and DONE.
- DRAIN: lasts exactly MIN_LAT cycles -> DONE.
- DONE: A <= running max, A_valid <= 1, done=1 for this cycle -> IDLE.
- A holds its value until the next DONE. It never falls below A_FLOOR.

## Timing
- start sampled at edge 0. win_valid is high in cycles 1..N with no hold. DRAIN occupies cycles N+1..N+MIN_LAT. done and the new A are seen in cycle N+MIN_LAT+1. busy drops with done.
- Each hold cycle during ISSUE delays done by one cycle.
- Reset values: busy=0, done=0, win_valid=0, win_x=0, win_y=0, A=A_FLOOR, A_valid=0, max_x=0, max_y=0; state IDLE, pipeline cleared.
- Reset mid-frame aborts the frame. In-flight results are discarded, no done pulse is produced, and A returns to A_FLOOR.
- start coinciding with DONE is ignored. It is accepted in the following IDLE cycle.

## Configuration
- ALIGHT_COORD_EN defined: max_x/max_y are latched in DONE with the coordinates of the window that set the final max. If no window beat A_FLOOR, they read 0.
- ALIGHT_COORD_EN undefined: the coordinate pipeline is not built. The max_x/max_y ports remain and are tied to 0.

## Test plan
All scenarios use IMG_W=IMG_H=5 (N=9, windows (1,1)..(3,3)), MIN_LAT=2 and ALIGHT_COORD_EN defined.
- All min_in=100, start at cycle 0 -> win_valid cycles 1-9, done at cycle 12, A=180, A_valid=1, max=(0,0).
- Window index 3 returns 200, all others 50 -> A=200, max_x=1, max_y=2.
- Windows 2 and 7 both return 220, all others 10 -> A=220, max=(3,1) (first occurrence).
- hold=1 during cycles 3-5 -> no issue in those cycles, coordinates frozen, done at cycle 15, A value identical to the same frame run without hold.
- reset pulsed at cycle 6 of a frame -> busy=0, A=180, A_valid=0, no done pulse; a following start completes normally at start+12.
- start re-asserted while busy, and again in the DONE cycle -> ignored; only one done pulse occurs; a start in the next IDLE cycle is accepted.
